// File: rtl/median5_pkg.sv
// Shared constants and state type for the 5-input median datapath
// (window feeder and median stage).
package median5_pkg;
  localparam int DW       = 8;
  localparam int TAPS     = 5;
  localparam int FILL_MAX = 5;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/median5_shreg.sv
// Five-tap sample shift register; taps[0] is the newest sample.
// Supports synchronous clear, shift-in load and load-all (edge replication).
module median5_shreg
  import median5_pkg::*;
#(
  parameter int W = median5_pkg::DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   load,
  input  logic                   replicate,
  input  logic [W-1:0]           din,
  output logic [TAPS-1:0][W-1:0] taps
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      taps <= '0;
    end else if (load) begin
      if (replicate) taps <= {TAPS{din}};
      else           taps <= {taps[TAPS-2:0], din};
    end
  end

endmodule

// File: rtl/median5_window.sv
// Serial sample stream to sliding 5-sample window with valid/ready on both sides.
// Optional MEDIAN5_WINDOW_REPLICATE_EN: first accept in FILL replicates din into all taps.
module median5_window
  import median5_pkg::*;
#(
  parameter int DW   = median5_pkg::DW,
  parameter int TAPS = median5_pkg::TAPS,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            ngreset,
  input  logic [DW-1:0]   din,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic            flush,
  output logic [DW-1:0]   data0,
  output logic [DW-1:0]   data1,
  output logic [DW-1:0]   data2,
  output logic [DW-1:0]   data3,
  output logic [DW-1:0]   data4,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      fill_cnt,
  output logic [CNTW-1:0] win_cnt
);

  if (TAPS != FILL_MAX) begin : g_taps_check
    $error("median5_window: TAPS must be 5");
  end

  state_t                   state;
  logic [4:0][DW-1:0]       taps;
  logic                     accept;
  logic                     handoff;
  logic                     load_all;
  logic [2:0]               fill_next;

  assign din_ready = !out_valid | out_ready;
  assign accept    = din_valid & din_ready & !flush;
  assign handoff   = out_valid & out_ready;

`ifdef MEDIAN5_WINDOW_REPLICATE_EN
  assign load_all = accept & (state == FILL);
`else
  assign load_all = 1'b0;
`endif

  // RUN is exactly fill_cnt==5, so it doubles as the saturation flag.
  assign fill_next = load_all         ? 3'(FILL_MAX) :
                     (state == RUN)   ? fill_cnt     :
                                        fill_cnt + 3'd1;

  median5_shreg #(.W(DW)) u_shreg (
    .clk       (clk),
    .rst       (ngreset),
    .clear     (flush),
    .load      (accept),
    .replicate (load_all),
    .din       (din),
    .taps      (taps)
  );

  assign data0 = taps[0];
  assign data1 = taps[1];
  assign data2 = taps[2];
  assign data3 = taps[3];
  assign data4 = taps[4];

  always_ff @(posedge clk) begin
    if (ngreset) begin
      state     <= FILL;
      out_valid <= 1'b0;
      fill_cnt  <= '0;
      win_cnt   <= '0;
    end else begin
      // A handshake in the same cycle as flush still counts.
      if (handoff) win_cnt <= win_cnt + CNTW'(1);

      if (flush) begin
        state     <= FILL;
        out_valid <= 1'b0;
        fill_cnt  <= '0;
      end else if (accept) begin
        fill_cnt <= fill_next;
        if (fill_next == 3'(FILL_MAX)) begin
          state     <= RUN;
          out_valid <= 1'b1;
        end else if (handoff) begin
          out_valid <= 1'b0;
        end
      end else if (handoff) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/median5_window.md
Name: median5_window

Overview:
- Upstream feeder for the 5-input median stage (data0..data4 → middata).
- Converts a serial 8-bit sample stream into a sliding 5-sample window, one new window per accepted sample.
- Valid/ready handshake on both sides; back-pressure from the median stage stalls the stream.
- Also counts emitted windows for debug.

Parameters:
- DW, 8, sample width; the median stage is 8-bit.
- TAPS, 5, window length; fixed at 5; any other value is a compile-time error.
- CNTW, 16, width of the emitted-window counter.

Ports:
- clk  in  1  single clock, rising edge
- ngreset  in  1  reset, synchronous, active-high (asserted = 1)
- din  in  DW  incoming sample
- din_valid  in  1  din is valid this cycle
- din_ready  out  1  block can accept din this cycle
- flush  in  1  discard window contents and restart fill
- data0  out  DW  newest sample in window
- data1  out  DW  second newest
- data2  out  DW  middle sample
- data3  out  DW  fourth newest
- data4  out  DW  oldest sample in window
- out_valid  out  1  data0..data4 form a full, unconsumed window
- out_ready  in  1  downstream consumes the window
- fill_cnt  out  3  samples held, 0..5
- win_cnt  out  CNTW  windows handed off (out_valid & out_ready)

Behaviour:
- Reset, sampled at a clk edge with ngreset=1:
  - data0..data4=0, out_valid=0, fill_cnt=0, win_cnt=0.
  - State=FILL.
  - Reset mid-stream drops the window and any pending out_valid immediately.
- din_ready = !out_valid | out_ready. This is combinational; there is no combinational path din_valid→din_ready.
- accept = din_valid & din_ready & !flush.
- On accept:
  - Shift: data4←data3, data3←data2, data2←data1, data1←data0, data0←din.
  - fill_cnt ← min(fill_cnt+1, 5).
- States:
  - FILL: fill_cnt<5.
  - RUN: fill_cnt==5.
  - FILL→RUN on the accept that makes fill_cnt 5.
  - RUN→FILL only on flush or reset.
- out_valid next-state:
  - 1 if accept and the post-accept fill_cnt==5 (the 5th sample and every later one).
  - Else 0 if out_valid & out_ready.
  - Else hold.
- Latency: sample accepted at edge N → window containing it is on data0..data4 with out_valid=1 after edge N.
- Stall: while out_valid=1 and out_ready=0, data0..data4 stay stable and din_ready=0.
- Simultaneous handoff and accept (out_valid & out_ready & accept): the window is consumed, the next window loads, out_valid stays 1, and win_cnt increments.
- win_cnt increments on each out_valid & out_ready and wraps modulo 2^CNTW.
- flush:
  - Priority: ngreset > flush > accept.
  - Action: taps←0, fill_cnt←0, out_valid←0, state FILL.
  - win_cnt is held. A simultaneous handshake still counts.
- Window values are stored unmodified; no arithmetic is performed on samples.

Optional Feature:
- Macro: MEDIAN5_WINDOW_REPLICATE_EN.
- Defined:
  - The first accept in FILL writes din into all five taps.
  - fill_cnt jumps to 5, and out_valid=1 on the next cycle.
  - This gives edge replication, so a median output exists from sample 1.
- Not defined: a normal 5-sample fill is required before the first out_valid.

Decomposition:
- Shared package median5_pkg:
  - DW and TAPS constants.
  - State enum {FILL, RUN}.
  - FILL_MAX=5.
  - The median stage also uses this package.
- One natural sub-module, median5_shreg: the 5-tap shift register with load/replicate/clear controls.
- Handshake, FSM and counters stay in the top module.

Test Plan:
- Reset, then din 6,8,9,3,12 on consecutive cycles with out_ready=1 → out_valid first rises after the 12; data0..data4=12,3,9,8,6; fill_cnt=5; win_cnt=1 one cycle later.
- Continue with din=5 → window 5,12,3,9,8; out_valid stays high every cycle; win_cnt increments each cycle.
- out_ready=0 for 3 cycles with din_valid=1 → din_ready=0, window frozen at 5,12,3,9,8; no sample is lost when out_ready returns.
- flush asserted together with din_valid → taps=0, fill_cnt=0, out_valid=0, din dropped; 4 further samples give no out_valid, the 5th does.
- ngreset=1 for one edge mid-RUN with out_valid=1 → all outputs 0 next cycle, win_cnt=0.
- With MEDIAN5_WINDOW_REPLICATE_EN: first din=7 → data0..data4=7,7,7,7,7, out_valid=1 after one edge.
